// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   // fetch port
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_rdata_o;
   logic              if_done_o;
   // data port
   logic              dm_req_i;
   logic              dm_we_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic [DATA_W-1:0] dm_rdata_o;
   logic              dm_done_o;
   // pipeline control
   logic              stall_o;
   // memory side
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ready_i;
   // status
   logic              err_o;

   // arbiter view
   modport slave (
      input  if_req_i, if_addr_i,
      output if_rdata_o, if_done_o,
      input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      output dm_rdata_o, dm_done_o,
      output stall_o,
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ready_i,
      output err_o
   );

   // requester / memory environment view
   modport master (
      output if_req_i, if_addr_i,
      input  if_rdata_o, if_done_o,
      output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
      input  dm_rdata_o, dm_done_o,
      input  stall_o,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ready_i,
      input  err_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Data port wins ties unless fetch has been passed over STARVE_LIMIT times in a row;
// every access is aborted after TIMEOUT busy cycles and flagged in a sticky error.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned TIMEOUT      = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned CNT_MAX = (TIMEOUT > STARVE_LIMIT + 1) ? TIMEOUT : STARVE_LIMIT + 1;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  busy_cnt;
   logic [CNT_W-1:0]  starve_cnt;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              err;

   logic              busy;
   logic              done;
   logic              grant_if;
   logic              grant_dm;
   logic [DATA_W-1:0] rdata;

   // Completion, grant decision and returned data for the current cycle.
   always_comb begin
      busy     = (state != IDLE);
      done     = busy && (bus.mem_ready_i || (busy_cnt == TO_LAST));
      grant_if = (state == IDLE) && bus.if_req_i &&
                 (!bus.dm_req_i || (starve_cnt == STARVE_MAX));
      grant_dm = (state == IDLE) && bus.dm_req_i && !grant_if;
      rdata    = (done && bus.mem_ready_i) ? bus.mem_rdata_i : '0;
   end

   assign bus.if_done_o   = done && (state == IF_BUSY);
   assign bus.dm_done_o   = done && (state == DM_BUSY);
   assign bus.if_rdata_o  = (state == IF_BUSY) ? rdata : '0;
   assign bus.dm_rdata_o  = (state == DM_BUSY) ? rdata : '0;
   assign bus.stall_o     = (bus.if_req_i && !bus.if_done_o) ||
                            (bus.dm_req_i && !bus.dm_done_o);
   assign bus.mem_req_o   = mem_req;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_wdata_o = mem_wdata;
   assign bus.err_o       = err;

   // Arbitration FSM with registered memory-side outputs and counters.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         busy_cnt   <= '0;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy_cnt <= '0;
               if (grant_dm) begin
                  state     <= DM_BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= bus.dm_we_i;
                  mem_addr  <= bus.dm_addr_i;
                  mem_wdata <= bus.dm_wdata_i;
                  // fetch passed over again: count toward forced fetch grant
                  if (!bus.if_req_i)
                     starve_cnt <= '0;
                  else if (starve_cnt != STARVE_MAX)
                     starve_cnt <= starve_cnt + CNT_W'(1);
               end else if (grant_if) begin
                  state      <= IF_BUSY;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= bus.if_addr_i;
                  mem_wdata  <= '0;
                  starve_cnt <= '0;
               end
            end
            IF_BUSY, DM_BUSY: begin
               if (done) begin
                  state    <= IDLE;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  busy_cnt <= '0;
                  // ready takes precedence over a coincident timeout
                  if (!bus.mem_ready_i)
                     err <= 1'b1;
               end else begin
                  busy_cnt <= busy_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule
